matmul_tile_engine: RTL
=======================

MATMUL_TILE_ENGINE -- requirements
Module: matmul_tile_engine

Interface
- REQ-001: Parameter M, default 4, is the number of rows of A and C.
- REQ-002: Parameter K, default 16, is the inner dimension (columns of A, rows of B).
- REQ-003: Parameter N, default 4, is the number of columns of B and C.
- REQ-004: Parameter DW, default 8, is the operand element width.
- REQ-005: Parameter AW, default 32, is the accumulator and result element width; AW SHALL be at least 2*DW.
- REQ-006: Parameter LANES, default 4, is the number of parallel MAC lanes; 1 <= LANES <= M*N.
- REQ-007: clk, input, 1 bit, rising-edge clock.
- REQ-008: rst_n, input, 1 bit, asynchronous active-low reset.
- REQ-009: start, input, 1 bit, requests an operation; honoured only in IDLE.
- REQ-010: abort, input, 1 bit, synchronous cancel of the operation in flight.
- REQ-011: signed_mode, input, 1 bit; 1 = two's-complement operands, 0 = unsigned.
- REQ-012: a_in, input, M*K*DW bits, matrix A row-major; element (i,k) at offset (i*K+k)*DW.
- REQ-013: b_in, input, K*N*DW bits, matrix B row-major; element (k,j) at offset (k*N+j)*DW.
- REQ-014: c_out, output, M*N*AW bits, matrix C row-major; element (i,j) at offset (i*N+j)*AW.
- REQ-015: busy, output, 1 bit, high while an operation is in flight.
- REQ-016: done, output, 1 bit, one-cycle pulse on completion.
- REQ-017: ovf, output, 1 bit, saturation occurred in the last completed operation.

Function
- REQ-018: FSM states SHALL be IDLE, RUN, DRAIN and FINISH; reset state is IDLE.
- REQ-019: IDLE with start=1 at edge T0 SHALL latch a_in, b_in and signed_mode, clear the accumulators, and enter RUN; busy is high from T0+1.
- REQ-020: Output elements e = i*N+j SHALL be processed in G = ceil(M*N/LANES) groups; group g covers e = g*LANES .. g*LANES+LANES-1.
- REQ-021: In RUN, each cycle SHALL issue one (g,k) pair, with k stepping 0..K-1 fastest, then g incrementing.
- REQ-022: Lanes whose e >= M*N SHALL multiply zero and their results SHALL be discarded.
- REQ-023: Products SHALL be registered (one pipeline stage), sign- or zero-extended to AW per the latched mode, then accumulated the following cycle.
- REQ-024: After the last pair (g=G-1, k=K-1) is issued, the FSM SHALL enter DRAIN for one cycle, then FINISH.
- REQ-025: In FINISH, the engine SHALL copy all accumulators to c_out and the sticky overflow to ovf, pulse done for one cycle, deassert busy, and return to IDLE.
- REQ-026: done SHALL be high exactly at cycle T0+G*K+2; with defaults this is T0+66.
- REQ-027: c_out and ovf SHALL hold their values between completions, unaffected by input changes.
- REQ-028: start while busy SHALL be ignored; start in the FINISH cycle SHALL be ignored; start may be accepted in the first IDLE cycle after done.
- REQ-029: abort=1 while busy SHALL force IDLE at the next edge, with busy low, no done, and c_out/ovf unchanged; abort has priority over every other transition.
- REQ-030: Without saturation, accumulation SHALL wrap modulo 2^AW.

Reset
- REQ-031: rst_n low SHALL asynchronously force IDLE, busy=0, done=0, ovf=0, all c_out elements to 0, and all accumulators and pipeline registers to 0.
- REQ-032: Reset asserted mid-operation SHALL discard the operation; after release, no done is produced until a new start is accepted.

Configuration
- REQ-033: Macro MATMUL_SAT_EN, when defined, SHALL make each accumulate clamp to [-2^(AW-1), 2^(AW-1)-1] in signed mode or [0, 2^AW-1] in unsigned mode, and set the sticky overflow on any clamp.
- REQ-034: When MATMUL_SAT_EN is undefined, accumulation SHALL wrap and ovf SHALL be tied to 0.

Verification
- REQ-035: Defaults, unsigned; A = identity-padded (a(i,i)=1), B(k,j) = k+j -> c(i,j) = i+j; done at T0+66.
- REQ-036: Defaults, unsigned, all elements 255 -> every c = 1040400; ovf = 0.
- REQ-037: Defaults, signed, all elements 0x80 -> every c = 262144.
- REQ-038: AW=16, unsigned, all 255 -> c = 65535 and ovf = 1 with MATMUL_SAT_EN; c = 57360 and ovf = 0 without. AW=16, signed, A=0x80 and B=0x7F -> c = -32768 with the macro.
- REQ-039: Abort at T0+20 -> no done, c_out retains the previous result; an immediate new start completes normally; start pulses during busy produce no extra done.
- REQ-040: LANES=3, M=N=2, K=4 -> G=2, done at T0+10, and the unused lane does not corrupt c(1,1).

Source files
------------

// File: rtl/matmul_tile_engine.sv
// rtl/matmul_tile_engine.sv - tiled integer matrix multiply C = A x B using LANES parallel MACs
// Build option MATMUL_SAT_EN: saturating accumulation with a sticky overflow flag on ovf.
module matmul_tile_engine #(
  parameter int M     = 4,
  parameter int K     = 16,
  parameter int N     = 4,
  parameter int DW    = 8,
  parameter int AW    = 32,
  parameter int LANES = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic              signed_mode,
  input  logic [M*K*DW-1:0] a_in,
  input  logic [K*N*DW-1:0] b_in,
  output logic [M*N*AW-1:0] c_out,
  output logic              busy,
  output logic              done,
  output logic              ovf
);
  localparam int MN = M * N;
  localparam int G  = (MN + LANES - 1) / LANES;
  localparam int GW = (G > 1) ? $clog2(G) : 1;
  localparam int KW = (K > 1) ? $clog2(K) : 1;
  localparam int PW = (AW > 2*DW+2) ? AW : 2*DW+2;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, FINISH} state_t;
  state_t r_state, w_next;

  logic [M*K*DW-1:0] r_a;
  logic [K*N*DW-1:0] r_b;
  logic              r_sm;
  logic [GW-1:0]     r_g, r_pg;
  logic [KW-1:0]     r_k;
  logic              r_pvalid;
  logic [AW-1:0]     r_prod [LANES];
  logic [AW-1:0]     w_prod [LANES];
  logic [AW-1:0]     r_acc [MN];
  logic [AW-1:0]     w_acc_nxt [MN];
  logic [MN-1:0]     w_sat;
  logic              r_sov, r_ovf, r_done;
  logic [M*N*AW-1:0] r_c;
  logic              w_accept, w_last;

  function automatic int elem_idx(input logic [GW-1:0] g, input int l);
    return int'(g) * LANES + l;
  endfunction

  // Operands are widened by one bit so unsigned and signed share one signed multiplier.
  function automatic logic [AW-1:0] mul_ext(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                            input logic sm);
    logic signed [PW-1:0] pa, pb, pp;
    pa = PW'($signed({sm & a[DW-1], a}));
    pb = PW'($signed({sm & b[DW-1], b}));
    pp = pa * pb;
    return AW'(pp);
  endfunction

  // Returns {clamped, next accumulator value}.
  function automatic logic [AW:0] acc_step(input logic [AW-1:0] acc, input logic [AW-1:0] p,
                                           input logic sm);
    logic [AW:0] s;
    s = {sm & acc[AW-1], acc} + {sm & p[AW-1], p};
`ifdef MATMUL_SAT_EN
    if (sm && (s[AW] != s[AW-1])) return {1'b1, s[AW], {(AW-1){~s[AW]}}};
    if (!sm && s[AW]) return {1'b1, {AW{1'b1}}};
`endif
    return {1'b0, AW'(s)};
  endfunction

  assign w_accept = (r_state == IDLE) && start && !abort;
  assign w_last   = (r_g == GW'(G-1)) && (r_k == KW'(K-1));
  assign busy     = (r_state != IDLE);
  assign done     = r_done;
  assign ovf      = r_ovf;
  assign c_out    = r_c;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (start) w_next = RUN;
      RUN:     if (w_last) w_next = DRAIN;
      DRAIN:   w_next = FINISH;
      FINISH:  w_next = IDLE;
      default: w_next = IDLE;
    endcase
    if (abort) w_next = IDLE;
  end

  always_comb begin
    for (int l = 0; l < LANES; l++) begin
      w_prod[l] = '0;
      if (elem_idx(r_g, l) < MN)
        w_prod[l] = mul_ext(r_a[((elem_idx(r_g, l) / N) * K + int'(r_k)) * DW +: DW],
                            r_b[(int'(r_k) * N + elem_idx(r_g, l) % N) * DW +: DW], r_sm);
    end
  end

  always_comb begin
    for (int e = 0; e < MN; e++) begin
      w_acc_nxt[e] = r_acc[e];
      w_sat[e]     = 1'b0;
    end
    if (r_pvalid) begin
      for (int l = 0; l < LANES; l++) begin
        if (elem_idx(r_pg, l) < MN)
          {w_sat[elem_idx(r_pg, l)], w_acc_nxt[elem_idx(r_pg, l)]} =
            acc_step(r_acc[elem_idx(r_pg, l)], r_prod[l], r_sm);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a      <= '0;
      r_b      <= '0;
      r_sm     <= 1'b0;
      r_g      <= '0;
      r_k      <= '0;
      r_pg     <= '0;
      r_pvalid <= 1'b0;
      r_sov    <= 1'b0;
      r_ovf    <= 1'b0;
      r_done   <= 1'b0;
      r_c      <= '0;
      for (int l = 0; l < LANES; l++) r_prod[l] <= '0;
      for (int e = 0; e < MN; e++) r_acc[e] <= '0;
    end else begin
      r_done   <= 1'b0;
      r_pvalid <= (r_state == RUN) && !abort;
      r_pg     <= r_g;
      for (int l = 0; l < LANES; l++) r_prod[l] <= w_prod[l];
      if (w_accept) begin
        r_a   <= a_in;
        r_b   <= b_in;
        r_sm  <= signed_mode;
        r_g   <= '0;
        r_k   <= '0;
        r_sov <= 1'b0;
        for (int e = 0; e < MN; e++) r_acc[e] <= '0;
      end else begin
        for (int e = 0; e < MN; e++) r_acc[e] <= w_acc_nxt[e];
        if (|w_sat) r_sov <= 1'b1;
        if (r_state == RUN) begin
          if (r_k == KW'(K-1)) begin
            r_k <= '0;
            r_g <= r_g + GW'(1);
          end else begin
            r_k <= r_k + KW'(1);
          end
        end
        if (r_state == FINISH && !abort) begin
          r_done <= 1'b1;
          r_ovf  <= r_sov;
          for (int e = 0; e < MN; e++) r_c[e*AW +: AW] <= r_acc[e];
        end
      end
    end
  end
endmodule
